// File: rtl/out_sig_monitor.sv
`timescale 1ns/1ps
// Purpose : compresses a stream of valid DUT output samples into a 32-bit MISR signature and checks it against a golden value.
// Latency : one edge per sample; done/match visible one cycle after the last valid sample (or one edge after start when num_cycles==0).
// Backpress: none; the observer never stalls, obs_valid simply qualifies each sample and low cycles hold state.
module out_sig_monitor #(
  parameter int unsigned OUT_W = 159,
  parameter int unsigned CNT_W = 16,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter logic [31:0] SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic             obs_valid,
  input  logic [OUT_W-1:0] obs_data,
  input  logic [31:0]      exp_sig,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sig,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             match
);

  // Observed bus is zero-padded up to a whole number of 32-bit chunks.
  localparam int NCHUNK = (OUT_W + 31) / 32;
  localparam int EXT_W  = NCHUNK * 32;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             match_q, match_d;

  logic [EXT_W-1:0] obs_ext;
  logic [31:0]      fold;
  logic [31:0]      sig_upd;
  logic [CNT_W-1:0] cnt_inc;

  // Fold the padded sample into 32 bits by XOR-ing every chunk together.
  always_comb begin
    obs_ext = '0;
    obs_ext[OUT_W-1:0] = obs_data;
    fold = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      fold = fold ^ obs_ext[i*32 +: 32];
    end
  end

  // One MISR shift with polynomial feedback plus the folded sample.
  always_comb begin
    sig_upd = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold;
    cnt_inc = cnt_q + CNT_ONE;
  end

  // Next-state logic: start is honoured only outside RUN; IDLE is left forever once a run begins.
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    match_d = match_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sig_d = SEED;
          cnt_d = '0;
          tgt_d = num_cycles;
          if (num_cycles == '0) begin
            // Empty run: the signature is just the seed, judged right away.
            state_d = ST_DONE;
            match_d = (SEED == exp_sig);
          end else begin
            state_d = ST_RUN;
            match_d = 1'b0;
          end
        end
      end
      ST_RUN: begin
        if (obs_valid) begin
          sig_d = sig_upd;
          cnt_d = cnt_inc;
          // Target is never above 2^CNT_W-1, so the counter stops before it could wrap.
          if (cnt_inc == tgt_q) begin
            state_d = ST_DONE;
            match_d = (sig_upd == exp_sig);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial run at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      tgt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      match_q <= match_d;
    end
  end

  // Outputs come straight from registers; busy/done are state decodes.
  always_comb begin
    busy       = (state_q == ST_RUN);
    done       = (state_q == ST_DONE);
    sig        = sig_q;
    sample_cnt = cnt_q;
    match      = match_q;
  end

endmodule

// File: tb/tb_out_sig_monitor.sv
`timescale 1ns/1ps
// Bench for out_sig_monitor: drives capture runs, queues the model's result per run, compares when done rises.
module tb_out_sig_monitor;

  localparam int OUT_W = 159;
  localparam int CNT_W = 16;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_cycles;
  logic             obs_valid;
  logic [OUT_W-1:0] obs_data;
  logic [31:0]      exp_sig;
  logic             busy;
  logic             done;
  logic [31:0]      sig;
  logic [CNT_W-1:0] sample_cnt;
  logic             match;

  out_sig_monitor #(
    .OUT_W(OUT_W), .CNT_W(CNT_W), .POLY(POLY), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_cycles(num_cycles),
    .obs_valid(obs_valid), .obs_data(obs_data), .exp_sig(exp_sig),
    .busy(busy), .done(done), .sig(sig), .sample_cnt(sample_cnt), .match(match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string            tag;
    logic [31:0]      sig;
    logic [CNT_W-1:0] cnt;
    logic             match;
    int               cycles;
  } exp_t;

  exp_t             exp_q[$];
  logic [OUT_W-1:0] stim_q[$];
  logic [OUT_W-1:0] saved[$];
  logic [31:0]      last_sig;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference fold: bit b of the sample lands on bit b mod 32.
  function automatic logic [31:0] ref_fold(input logic [OUT_W-1:0] d);
    logic [31:0] f;
    f = '0;
    for (int b = 0; b < OUT_W; b++) f[b % 32] = f[b % 32] ^ d[b];
    return f;
  endfunction

  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [OUT_W-1:0] d);
    logic [31:0] n;
    n = {s[30:0], 1'b0};
    if (s[31]) n = n ^ POLY;
    return n ^ ref_fold(d);
  endfunction

  function automatic logic [OUT_W-1:0] junk();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[OUT_W-1:0];
  endfunction

  // One capture run using the first n entries of stim_q; vmask bit i = obs_valid in RUN cycle i (1 beyond bit 31).
  task automatic do_run(input string tag, input int n, input logic [31:0] esig,
                        input logic [31:0] vmask, input bit poke);
    exp_t        e;
    logic [31:0] s;
    int          ones, cyc, k, cycles;
    bit          v;
    s = SEED;
    for (int j = 0; j < n; j++) s = ref_step(s, stim_q[j]);
    cyc = 0; ones = 0;
    while (ones < n) begin
      if (cyc >= 32 || vmask[cyc]) ones++;
      cyc++;
    end
    e.tag = tag; e.sig = s; e.cnt = n[CNT_W-1:0]; e.match = (s == esig); e.cycles = cyc;
    exp_q.push_back(e);

    @(negedge clk);
    start = 1'b1; num_cycles = n[CNT_W-1:0]; exp_sig = esig; obs_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0; cycles = 0;
    while (!done && cycles < 200) begin
      if (cycles == 0) check_val({tag, "/busy"}, 64'(busy), 64'(1));
      check_val({tag, "/cnt_run"}, 64'(sample_cnt), 64'(k));
      v = (cycles >= 32) || vmask[cycles];
      obs_valid = v;
      obs_data  = v ? stim_q[k] : junk();
      if (poke && cycles == 1) begin
        start = 1'b1; num_cycles = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (v) k++;
      cycles++;
    end
    start = 1'b0; obs_valid = 1'b0;
    for (int j = 0; j < n; j++) void'(stim_q.pop_front());

    e = exp_q.pop_front();
    check_val({e.tag, "/done"},   64'(done),       64'(1));
    check_val({e.tag, "/cycles"}, 64'(cycles),     64'(e.cycles));
    check_val({e.tag, "/sig"},    64'(sig),        64'(e.sig));
    check_val({e.tag, "/cnt"},    64'(sample_cnt), 64'(e.cnt));
    check_val({e.tag, "/match"},  64'(match),      64'(e.match));
    check_val({e.tag, "/busy0"},  64'(busy),       64'(0));
    last_sig = sig;

    // DONE without start must hold everything even with valid traffic present.
    obs_valid = 1'b1; obs_data = junk();
    @(negedge clk);
    obs_valid = 1'b0;
    check_val({e.tag, "/hold_sig"},   64'(sig),   64'(e.sig));
    check_val({e.tag, "/hold_match"}, 64'(match), 64'(e.match));
    check_val({e.tag, "/hold_done"},  64'(done),  64'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "/busy"},  64'(busy),       64'(0));
    check_val({tag, "/done"},  64'(done),       64'(0));
    check_val({tag, "/sig"},   64'(sig),        64'(SEED));
    check_val({tag, "/cnt"},   64'(sample_cnt), 64'(0));
    check_val({tag, "/match"}, 64'(match),      64'(0));
  endtask

  initial begin
    logic [31:0] u;
    rst_n = 1'b0; start = 1'b0; num_cycles = '0; obs_valid = 1'b0;
    obs_data = '0; exp_sig = '0; last_sig = '0;
    #22;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    // Idle ignores traffic until start.
    obs_valid = 1'b1; obs_data = junk();
    repeat (3) @(negedge clk);
    obs_valid = 1'b0;
    check_reset_vals("idle");

    stim_q.push_back('0);
    do_run("zero_data", 1, 32'h0, 32'hFFFFFFFF, 1'b0);
    check_val("zero_data/lit", 64'(last_sig), 64'(32'hFB3EE249));

    stim_q.push_back({{(OUT_W-1){1'b0}}, 1'b1});
    do_run("one_match", 1, 32'hFB3EE248, 32'hFFFFFFFF, 1'b0);
    check_val("one_match/lit", 64'(last_sig), 64'(32'hFB3EE248));

    stim_q.push_back({{(OUT_W-1){1'b0}}, 1'b1});
    do_run("one_nomatch", 1, 32'h0, 32'hFFFFFFFF, 1'b0);

    stim_q.push_back({OUT_W{1'b1}});
    do_run("all_ones", 1, 32'h0, 32'hFFFFFFFF, 1'b0);
    check_val("all_ones/lit", 64'(last_sig), 64'(32'h84C11DB6));

    for (int j = 0; j < 3; j++) saved.push_back(junk());
    for (int j = 0; j < 3; j++) stim_q.push_back(saved[j]);
    do_run("ungapped3", 3, 32'h0, 32'hFFFFFFFF, 1'b0);
    u = last_sig;
    for (int j = 0; j < 3; j++) stim_q.push_back(saved[j]);
    do_run("gapped3", 3, u, 32'h00000019, 1'b1);

    do_run("empty", 0, SEED, 32'hFFFFFFFF, 1'b0);
    check_val("empty/lit", 64'(last_sig), 64'(32'hFFFFFFFF));

    for (int j = 0; j < 20; j++) stim_q.push_back(junk());
    do_run("rand20", 20, 32'h0, $urandom | 32'h1, 1'b1);

    // Reset in the middle of a run.
    saved.delete();
    for (int j = 0; j < 10; j++) saved.push_back(junk());
    @(negedge clk);
    start = 1'b1; num_cycles = 16'd10; exp_sig = '0;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      obs_valid = 1'b1; obs_data = saved[j];
      @(negedge clk);
    end
    obs_valid = 1'b0;
    check_val("midrun/cnt_before", 64'(sample_cnt), 64'(4));
    check_val("midrun/busy_before", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("post_rst_idle");
    for (int j = 0; j < 10; j++) stim_q.push_back(saved[j]);
    do_run("post_rst", 10, 32'h0, 32'hFFFFFFFF, 1'b0);

    check_val("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
